// File: rtl/vscpu_pkg.sv
// Shared definitions for the VSCPU memory responder: default address width,
// memory depth derivation and the responder state encoding.
package vscpu_pkg;

  localparam int VSCPU_SIZE = 14;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int vscpu_depth(input int size);
    return 2 ** size;
  endfunction

  localparam int VSCPU_DEPTH = vscpu_depth(VSCPU_SIZE);

endpackage

// File: rtl/vscpu_ram_array.sv
// Word storage with one write port and a registered read-first read port.
// The array itself has no reset; only the read register clears.
module vscpu_ram_array
  import vscpu_pkg::*;
#(
  parameter int AW    = VSCPU_SIZE,
  parameter int DEPTH = vscpu_depth(AW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register samples the old word on a same-address write (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
    end else if (rd_en) begin
      rdata_q <= mem[raddr];
    end else begin
      rdata_q <= 32'd0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vscpu_mem_responder.sv
// CPU-facing memory responder with a program loader that holds the CPU in
// reset while a program image is streamed into memory.
module vscpu_mem_responder
  import vscpu_pkg::*;
#(
  parameter int SIZE  = VSCPU_SIZE,
  parameter int DEPTH = vscpu_depth(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wrEn,
  input  logic [SIZE-1:0] addr_toRAM,
  input  logic [31:0]     data_toRAM,
  output logic [31:0]     data_fromRAM,
  input  logic            ld_start,
  input  logic [SIZE-1:0] ld_base,
  input  logic            ld_valid,
  input  logic [31:0]     ld_data,
  input  logic            ld_last,
  output logic            ld_ready,
  output logic            cpu_hold,
  output logic [SIZE:0]   ld_words
);

  localparam logic [SIZE-1:0] PTR_LAST  = SIZE'(DEPTH - 1);
  localparam logic [SIZE:0]   WORDS_MAX = {1'b1, {SIZE{1'b0}}};

  state_e          state_q, state_d;
  logic [SIZE-1:0] ld_ptr_q, ld_ptr_d;
  logic [SIZE:0]   ld_words_q, ld_words_d;
  logic            ld_ready_q;
  logic            cpu_hold_q;
  logic            mem_we_s;
  logic [SIZE-1:0] mem_waddr_s;
  logic [31:0]     mem_wdata_s;
  logic            rd_en_s;

  // Next-state, loader pointer/count and the shared write-port mux.
  always_comb begin
    state_d     = state_q;
    ld_ptr_d    = ld_ptr_q;
    ld_words_d  = ld_words_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_toRAM;
    mem_wdata_s = data_toRAM;
    rd_en_s     = (state_q == ST_SERVE);
    case (state_q)
      ST_SERVE: begin
        mem_we_s = wrEn;
        if (ld_start) begin
          state_d    = ST_LOAD;
          ld_ptr_d   = ld_base;
          ld_words_d = {(SIZE+1){1'b0}};
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = ld_ptr_q;
          mem_wdata_s = ld_data;
          ld_ptr_d    = (ld_ptr_q == PTR_LAST) ? {SIZE{1'b0}} : ld_ptr_q + 1'b1;
          ld_words_d  = (ld_words_q == WORDS_MAX) ? ld_words_q : ld_words_q + 1'b1;
          state_d     = ld_last ? ST_DONE : ST_LOAD;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_SERVE;
      end
      default: begin
        state_d = ST_SERVE;
      end
    endcase
  end

  // State and registered handshake/hold outputs, derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_SERVE;
      ld_ptr_q   <= {SIZE{1'b0}};
      ld_words_q <= {(SIZE+1){1'b0}};
      ld_ready_q <= 1'b0;
      cpu_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_ptr_q   <= ld_ptr_d;
      ld_words_q <= ld_words_d;
      ld_ready_q <= (state_d == ST_LOAD);
      cpu_hold_q <= (state_d != ST_SERVE);
    end
  end

  vscpu_ram_array #(
    .AW    (SIZE),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst),
    .we    (mem_we_s),
    .waddr (mem_waddr_s),
    .wdata (mem_wdata_s),
    .rd_en (rd_en_s),
    .raddr (addr_toRAM),
    .rdata (data_fromRAM)
  );

  assign ld_ready = ld_ready_q;
  assign cpu_hold = cpu_hold_q;
  assign ld_words = ld_words_q;

endmodule

// File: doc/vscpu_mem_responder.md
VSCPU_MEM_RESPONDER -- requirements
Module: vscpu_mem_responder

Interface
REQ-001 SHALL have parameter SIZE, default 14, meaning word-address width.
REQ-002 SHALL have parameter DEPTH, default 2**SIZE, meaning number of 32-bit words stored.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wrEn  input  1  CPU write strobe.
REQ-006 SHALL have port addr_toRAM  input  SIZE  CPU word address.
REQ-007 SHALL have port data_toRAM  input  32  CPU write data.
REQ-008 SHALL have port data_fromRAM  output  32  registered read data to CPU.
REQ-009 SHALL have port ld_start  input  1  one-cycle pulse beginning a program load.
REQ-010 SHALL have port ld_base  input  SIZE  first address of the load, sampled with ld_start.
REQ-011 SHALL have port ld_valid  input  1  loader word valid.
REQ-012 SHALL have port ld_data  input  32  loader word.
REQ-013 SHALL have port ld_last  input  1  marks final loader word, qualified by ld_valid.
REQ-014 SHALL have port ld_ready  output  1  responder accepts loader word this cycle.
REQ-015 SHALL have port cpu_hold  output  1  CPU must be held in reset while high.
REQ-016 SHALL have port ld_words  output  SIZE+1  words accepted in the current or last load, saturating.

Function
REQ-017 SHALL implement FSM states SERVE, LOAD, DONE: SERVE->LOAD on ld_start; LOAD->DONE on accepted word with ld_last=1; DONE->SERVE unconditionally after one cycle.
REQ-018 SHALL, in SERVE, drive data_fromRAM <= mem[addr_toRAM] on every rising edge: exactly one-cycle read latency.
REQ-019 SHALL, in SERVE with wrEn=1, write data_toRAM to mem[addr_toRAM] at the rising edge.
REQ-020 SHALL be read-first: read and write to the same address in one cycle returns the old word; the new word is visible the following cycle.
REQ-021 SHALL, on ld_start in SERVE, load ld_ptr <= ld_base, clear ld_words to 0, enter LOAD next cycle.
REQ-022 SHALL drive ld_ready=1 only in LOAD; a word is accepted when ld_valid&&ld_ready.
REQ-023 SHALL write each accepted word to mem[ld_ptr] and increment ld_ptr modulo DEPTH (DEPTH-1 wraps to 0).
REQ-024 SHALL increment ld_words per accepted word, saturating at 2**SIZE.
REQ-025 SHALL drive cpu_hold=1 in LOAD and DONE, 0 in SERVE (registered, from state).
REQ-026 SHALL, in LOAD and DONE, ignore wrEn (no memory change) and hold data_fromRAM at 0.
REQ-027 SHALL ignore ld_start while in LOAD or DONE.
REQ-028 SHALL, in SERVE, treat ld_valid/ld_last as don't-care (no write, no count change).
REQ-029 SHALL accept a ld_last word with no prior words as a one-word load (ld_words=1).
REQ-030 SHALL resume SERVE reads the cycle after DONE; first CPU read returns loaded data.

Reset
REQ-031 SHALL, while rst=0, force state SERVE, data_fromRAM=0, ld_ready=0, cpu_hold=0, ld_ptr=0, ld_words=0, immediately and independent of clk.
REQ-032 SHALL NOT reset memory contents; words written before reset remain after.
REQ-033 SHALL abort a load on reset mid-LOAD: words already written stay, no further writes.

Structure
REQ-034 SHALL take SIZE default, DEPTH derivation and the SERVE/LOAD/DONE state encoding from shared package vscpu_pkg.
REQ-035 SHALL place the storage array in one sub-module vscpu_ram_array (single write port, registered read-first read port); FSM, mux and counters stay in vscpu_mem_responder.

Verification
REQ-036 SHALL test read latency: write 32'h0000_0005 to addr 100, then read 100 -> data_fromRAM=32'h5 exactly one cycle after address presented.
REQ-037 SHALL test read-first: mem[101]=32'hA, write 32'h3D to 101 while reading 101 -> 32'hA, next cycle 32'h3D.
REQ-038 SHALL test load: ld_start, ld_base=0, words 32'h00190065, 32'h10190003, 32'h40190066 (last) -> ld_words=3, cpu_hold high LOAD..DONE, mem[0..2] match, SERVE after DONE.
REQ-039 SHALL test wrap: ld_base=16383, two words -> written to 16383 and 0, ld_ptr=1.
REQ-040 SHALL test blocking: wrEn=1 addr 105 data 32'hFFFF_FFFF during LOAD -> mem[105] unchanged, data_fromRAM=0.
REQ-041 SHALL test reset mid-load: rst low after 2 of 4 words -> outputs at reset values within the same cycle, mem keeps 2 words, no writes afterward.
